// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch stage and the parse unit.
//   - fetch_state_e: fetch sequencer states.
//   - DEF_BUNDLE_W / DEF_ADDR_W: default bundle and address widths.
//   - Bundle field positions used when the parse unit decodes a bundle.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HALT     = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_e;

  localparam int DEF_BUNDLE_W = 60;
  localparam int DEF_ADDR_W   = 16;

  // Bundle layout, MSB first.
  localparam int FMT_BIT         = 59;
  localparam int BRANCH_BIT      = 58;
  localparam int OPCODE_MSB      = 57;
  localparam int OPCODE_LSB      = 51;
  localparam int PRIMARY_MSB     = 50;
  localparam int PRIMARY_LSB     = 46;
  localparam int SECONDARY_MSB   = 45;
  localparam int SECONDARY_S_LSB = 41;  // short (5-bit) secondary
  localparam int SECONDARY_L_LSB = 30;  // long (16-bit) secondary

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: show-ahead synchronous FIFO of {pc, bundle} entries.
//   clock_i/reset_n_i  clock, async active-low reset
//   flush_i            empty the FIFO (wins over push/pop)
//   push_i/push_data_i write one entry
//   pop_i              drop the head entry
//   head_data_o        head entry (valid when head_valid_o)
//   head_valid_o       FIFO non-empty
//   count_o            number of stored entries
module fetch_fifo #(
  parameter int WIDTH = 76,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    pop_ok_s  = pop_i && (count_r != '0);
    push_ok_s = push_i && ((count_r != FULL_CNT) || pop_ok_s);
  end

  // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data_i;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  assign head_data_o  = mem_r[rd_ptr_r];
  assign head_valid_o = (count_r != '0);
  assign count_o      = count_r;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction store + PC + credit-controlled prefetch FIFO feeding
// the parse unit over a valid/ready handshake.
//   halt_i                      stop fetching, enable store writes
//   flushBack_i                 drop queued/in-flight bundles, PC kept
//   writeEnable_i/Address/instruction_i  store write port (only while halted)
//   shouldBranch_i + branch*_i  redirect PC (absolute or base +/- offset)
//   data_o/pc_o/enable_o        head bundle, its address, valid
//   ready_i                     parse unit consumes the head
//   busy_o                      a read is in flight or the FIFO holds data
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                BUNDLE_W   = DEF_BUNDLE_W,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DEPTH      = 256,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                halt_i,
  input  logic                flushBack_i,
  input  logic                writeEnable_i,
  input  logic [ADDR_W-1:0]   writeAddress_i,
  input  logic [BUNDLE_W-1:0] instruction_i,
  input  logic                shouldBranch_i,
  input  logic                branchAbsolute_i,
  input  logic                branchDirection_i,
  input  logic [ADDR_W-1:0]   branchBase_i,
  input  logic [ADDR_W-1:0]   branchOffset_i,
  output logic [BUNDLE_W-1:0] data_o,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                enable_o,
  input  logic                ready_i,
  output logic                busy_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int ENT_W = ADDR_W + BUNDLE_W;

  logic [BUNDLE_W-1:0] store_r [DEPTH];
  logic [BUNDLE_W-1:0] rd_data_r;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   inflight_pc_r;
  logic                inflight_r;
  fetch_state_e        state_r;

  logic                kill_s;
  logic                pop_s;
  logic                push_s;
  logic                credit_s;
  logic                issue_s;
  logic                wr_ok_s;
  logic [ADDR_W-1:0]   target_s;
  logic [OCC_W-1:0]    occupancy_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic [ENT_W-1:0]    head_s;
  logic                head_valid_s;

  // Issue/credit decision, handshake and redirect target.
  always_comb begin
    // A branch or flush discards everything queued, including a same-cycle pop.
    kill_s      = shouldBranch_i || flushBack_i;
    pop_s       = head_valid_s && ready_i && !kill_s;
    push_s      = inflight_r && !kill_s;
    // Slots already promised: stored entries plus the read that lands next cycle.
    occupancy_s = OCC_W'(fifo_count_s) + OCC_W'(inflight_r) - OCC_W'(pop_s);
    credit_s    = (occupancy_s < OCC_W'(FIFO_DEPTH));
    issue_s     = (state_r == RUN) && !halt_i && credit_s && !kill_s;
    wr_ok_s     = halt_i && writeEnable_i && (32'(writeAddress_i) < 32'(DEPTH));
    if (branchAbsolute_i) begin
      target_s = branchOffset_i;
    end else if (branchDirection_i) begin
      target_s = branchBase_i + branchOffset_i;
    end else begin
      target_s = branchBase_i - branchOffset_i;
    end
  end

  // Instruction store: unreset contents, synchronous read (old data on collision).
  always_ff @(posedge clock_i) begin
    if (wr_ok_s) begin
      store_r[writeAddress_i[IDX_W-1:0]] <= instruction_i;
    end
    if (issue_s) begin
      rd_data_r <= store_r[pc_r[IDX_W-1:0]];
    end
  end

  // PC, in-flight tracking and fetch state machine.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= '0;
      state_r       <= RUN;
    end else if (shouldBranch_i) begin
      pc_r       <= target_s;
      inflight_r <= 1'b0;
      state_r    <= REDIRECT;
    end else begin
      // issue_s is already low during a flush, which kills the in-flight read.
      inflight_r <= issue_s;
      if (issue_s) begin
        pc_r          <= pc_r + ADDR_W'(1);
        inflight_pc_r <= pc_r;
      end
      case (state_r)
        RUN:      if (halt_i)  state_r <= HALT;
        HALT:     if (!halt_i) state_r <= RUN;
        REDIRECT: state_r <= halt_i ? HALT : RUN;
        default:  state_r <= RUN;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_i      (clock_i),
    .reset_n_i    (reset_n_i),
    .flush_i      (kill_s),
    .push_i       (push_s),
    .push_data_i  ({inflight_pc_r, rd_data_r}),
    .pop_i        (pop_s),
    .head_data_o  (head_s),
    .head_valid_o (head_valid_s),
    .count_o      (fifo_count_s)
  );

  assign {pc_o, data_o} = head_s;
  assign enable_o       = head_valid_s;
  assign busy_o         = inflight_r || (fifo_count_s != '0);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + randomized bench for fetch_queue with a
// queue-based reference model of the fetch stage.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, flush, we, br, babs, bdir, ready;
  logic [15:0] waddr, bbase, boff;
  logic [59:0] wdata;
  logic [59:0] data_o;
  logic [15:0] pc_o;
  logic        enable_o, busy_o;

  fetch_queue dut (
    .clock_i          (clk),
    .reset_n_i        (rst_n),
    .halt_i           (halt),
    .flushBack_i      (flush),
    .writeEnable_i    (we),
    .writeAddress_i   (waddr),
    .instruction_i    (wdata),
    .shouldBranch_i   (br),
    .branchAbsolute_i (babs),
    .branchDirection_i(bdir),
    .branchBase_i     (bbase),
    .branchOffset_i   (boff),
    .data_o           (data_o),
    .pc_o             (pc_o),
    .enable_o         (enable_o),
    .ready_i          (ready),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  // Reference model: bundles queued for the parse unit, reads in flight, PC, mode.
  typedef struct packed {
    logic [15:0] pc;
    logic [59:0] data;
  } ent_t;
  ent_t        mq[$];
  ent_t        mif[$];
  logic [59:0] mstore [256];
  logic [15:0] mpc;
  int          mmode;  // 0 running, 1 halted, 2 bubble after redirect
  logic [59:0] orig4, orig44, orig255;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mif.delete();
    mpc   = 16'h0000;
    mmode = 0;
  endtask

  task automatic model_edge();
    bit          pop, issue;
    ent_t        e;
    int          occ;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop = (mq.size() != 0) && ready;
    if (br) begin
      if (babs)      mpc = boff;
      else if (bdir) mpc = bbase + boff;
      else           mpc = bbase - boff;
      mq.delete();
      mif.delete();
      mmode = 2;
    end else begin
      if (flush) begin
        mq.delete();
        mif.delete();
      end else begin
        occ   = mq.size() + mif.size() - (pop ? 1 : 0);
        issue = (mmode == 0) && !halt && (occ < 4);
        if (pop) void'(mq.pop_front());
        if (mif.size() != 0) mq.push_back(mif.pop_front());
        if (issue) begin
          e.pc   = mpc;
          e.data = mstore[mpc[7:0]];
          mif.push_back(e);
          mpc = mpc + 16'd1;
        end
      end
      if (mmode == 0 && halt) mmode = 1;
      else if (mmode == 1 && !halt) mmode = 0;
      else if (mmode == 2) mmode = halt ? 1 : 0;
    end
    if (halt && we && waddr < 16'd256) mstore[waddr[7:0]] = wdata;
  endtask

  task automatic model_check();
    chk("m_enable", 64'(enable_o), 64'(mq.size() != 0));
    chk("m_busy", 64'(busy_o), 64'((mq.size() != 0) || (mif.size() != 0)));
    if (mq.size() != 0) begin
      chk("m_pc", 64'(pc_o), 64'(mq[0].pc));
      chk("m_data", 64'(data_o), 64'(mq[0].data));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic wait_enable(input string tag);
    for (int k = 0; k < 12 && !enable_o; k++) step();
    chk(tag, 64'(enable_o), 64'd1);
  endtask

  task automatic pulse_abs(input logic [15:0] tgt);
    br = 1'b1; babs = 1'b1; boff = tgt;
    step();
    br = 1'b0; babs = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    rst_n = 1'b0; halt = 1'b1; flush = 1'b0; we = 1'b0; br = 1'b0;
    babs = 1'b0; bdir = 1'b0; ready = 1'b0;
    waddr = 16'h0; bbase = 16'h0; boff = 16'h0; wdata = 60'h0;
    model_reset();
    #12;
    chk("reset_enable", 64'(enable_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_data", 64'(data_o), 64'd0);
    chk("reset_pc", 64'(pc_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load the whole store while halted; entries 0..3 = 0xA..0xD.
    for (int i = 0; i < 256; i++) begin
      r = {$urandom(), $urandom()};
      we = 1'b1; waddr = 16'(i);
      wdata = (i < 4) ? 60'(10 + i) : r[59:0];
      if (i == 4)   orig4   = r[59:0];
      if (i == 44)  orig44  = r[59:0];
      if (i == 255) orig255 = r[59:0];
      step();
    end
    waddr = 16'd300; wdata = 60'hBAD_BAD;  // out of range: must be ignored
    step();

    // Load-and-run; the write below is attempted with halt low and must be ignored.
    halt = 1'b0; ready = 1'b1; we = 1'b1; waddr = 16'd4; wdata = 60'h0DEAD;
    step();
    we = 1'b0;
    wait_enable("run_start");
    for (int k = 0; k < 4; k++) begin
      chk("run_data", 64'(data_o), 64'(10 + k));
      chk("run_pc", 64'(pc_o), 64'(k));
      step();
    end
    chk("guard_halt_low", 64'(data_o), 64'(orig4));
    repeat (12) step();

    // Asynchronous reset mid-stream.
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_enable", 64'(enable_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Back-pressure: 10 cycles with ready low, then in-order delivery.
    repeat (10) step();
    chk("bp_enable", 64'(enable_o), 64'd1);
    chk("bp_pc", 64'(pc_o), 64'd0);
    chk("bp_data", 64'(data_o), 64'd10);
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_seq_valid", 64'(enable_o), 64'd1);
      chk("bp_seq_pc", 64'(pc_o), 64'(k));
      step();
    end

    // Relative backward branch 8 - 6 = 2.
    br = 1'b1; bdir = 1'b0; bbase = 16'd8; boff = 16'd6;
    step();
    br = 1'b0;
    chk("rel_bubble", 64'(enable_o), 64'd0);
    step(); step(); step();
    chk("rel_pc0", 64'(pc_o), 64'd2);
    chk("rel_data0", 64'(data_o), 64'd12);
    step();
    chk("rel_pc1", 64'(pc_o), 64'd3);

    // Absolute branch to the top of the address space, wrapping to 0.
    pulse_abs(16'hFFFF);
    step(); step(); step();
    chk("wrap_pc0", 64'(pc_o), 64'hFFFF);
    chk("wrap_data0", 64'(data_o), 64'(orig255));
    step();
    chk("wrap_pc1", 64'(pc_o), 64'h0000);
    chk("wrap_data1", 64'(data_o), 64'd10);

    // Entry 44 must be untouched by the write to address 300.
    pulse_abs(16'd44);
    wait_enable("guard_wait");
    chk("guard_oob", 64'(data_o), 64'(orig44));

    // Flush with the FIFO full and PC at 4.
    ready = 1'b0;
    pulse_abs(16'd0);
    repeat (10) step();
    chk("flush_pre_pc", 64'(pc_o), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", 64'(enable_o), 64'd0);
    ready = 1'b1;
    wait_enable("flush_wait");
    chk("flush_resume_pc", 64'(pc_o), 64'd4);

    // Flush and branch together: branch wins.
    flush = 1'b1;
    pulse_abs(16'h0020);
    flush = 1'b0;
    wait_enable("fb_wait");
    chk("fb_pc", 64'(pc_o), 64'h0020);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      r = {$urandom(), $urandom()};
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      br    = ($urandom_range(0, 29) == 0);
      babs  = $urandom_range(0, 1) == 1;
      bdir  = $urandom_range(0, 1) == 1;
      bbase = 16'($urandom());
      boff  = 16'($urandom_range(0, 600));
      flush = ($urandom_range(0, 29) == 0);
      we    = $urandom_range(0, 1) == 1;
      waddr = 16'($urandom_range(0, 319));
      wdata = r[59:0];
      step();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
